muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1, giving the width of the iteration counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port valid_i, input, 1 bit: request present.
REQ-006 SHALL have port ready_o, output, 1 bit: unit can accept a request.
REQ-007 SHALL have port op_i, input, md_op_t: one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports data1_i and data2_i, input, XLEN bits each: rs1 and rs2 operands.
REQ-009 SHALL have port flush_i, input, 1 bit: abort the in-flight operation (pipeline flush).
REQ-010 SHALL have port valid_o, output, 1 bit: result available.
REQ-011 SHALL have port out_ready_i, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port result_o, output, XLEN bits: operation result.

Function
REQ-013 SHALL implement the states IDLE, CALC, FIX and DONE; ready_o SHALL equal (state==IDLE).
REQ-014 SHALL accept a request when valid_i && ready_o && !flush_i, latching op_i, data1_i and data2_i at that edge.
REQ-015 SHALL, on a normal accept, go IDLE->CALC and take exactly XLEN cycles in CALC, then 1 cycle in FIX, then enter DONE; valid_o SHALL rise XLEN+2 cycles after the accept edge.
REQ-016 SHALL, in CALC, perform one radix-2 step per cycle on operand magnitudes: shift-add for multiply (2*XLEN-bit product) and restoring shift-subtract for divide.
REQ-017 SHALL, in FIX, apply the sign correction:
- MUL/MULH: negate if the signs of rs1 and rs2 differ.
- MULHSU: rs1 is signed, rs2 unsigned.
- DIV: quotient negative if the operand signs differ.
- REM: remainder takes the sign of rs1.
- Unsigned ops: no correction.
REQ-018 SHALL return the product bits [XLEN-1:0] for MUL and bits [2*XLEN-1:XLEN] for MULH, MULHSU and MULHU.
REQ-019 SHALL treat divide-by-zero as a special case, going IDLE->DONE directly so valid_o rises 1 cycle after accept:
- DIV/DIVU: result all ones.
- REM/REMU: result = rs1.
REQ-020 SHALL treat signed overflow (rs1 = most-negative value, rs2 = -1) as a special case with 1-cycle latency:
- DIV: result = rs1.
- REM: result = 0.
REQ-021 SHALL, in DONE, hold valid_o=1 and result_o stable until out_ready_i=1, then return to IDLE on that edge; there is no bypass, so no new request is accepted in that same cycle.
REQ-022 SHALL, on flush_i=1, go to IDLE at the next edge from any state, drop valid_o, and discard the in-flight result.
REQ-023 SHALL give flush_i priority over a simultaneous accept and over a simultaneous out_ready_i.
REQ-024 SHALL drive result_o=0 whenever valid_o=0.

Reset
REQ-025 SHALL, when rst_i is asserted, immediately force: state=IDLE, valid_o=0, result_o=0, counter=0, and all operand/accumulator registers=0.
REQ-026 SHALL abandon an operation interrupted by reset; after rst_i deasserts, ready_o=1 and no stale valid_o is produced.

Structure
REQ-027 SHALL take md_op_t (8-entry enum) and the XLEN-independent op-class helpers (is_div, is_signed_rs1, is_signed_rs2, is_high) from the shared defs package, alongside alu_op_t.
REQ-028 SHALL keep the FSM, the special-case detection and the sign fix-up in muldiv_unit itself.
REQ-029 SHALL place the per-cycle shift/add-subtract datapath in one sub-module, muldiv_step, which is purely combinational and XLEN-parametrised.

Verification (XLEN=32)
REQ-030 SHALL cover: MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, valid_o exactly 34 cycles after accept.
REQ-031 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-033 SHALL cover the 1-cycle special cases:
- DIVU 5 / 0 -> 0xFFFFFFFF.
- REM 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM 0x80000000 / 0xFFFFFFFF -> 0.
REQ-034 SHALL cover: flush_i pulsed 10 cycles into CALC -> ready_o=1 next cycle, valid_o never asserted; a new MUL 3 x 4 then returns 12.
REQ-035 SHALL cover: out_ready_i held low for 5 cycles in DONE -> result_o stable and ready_o=0 throughout; rst_i asserted mid-CALC -> valid_o=0 and ready_o=1 immediately.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and XLEN-independent operation-class helpers.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    function automatic logic is_div(input md_op_t op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_rem(input md_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_rs1(input md_op_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_rs2(input md_op_t op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_high(input md_op_t op);
        return (op == MULH) || (op == MULHSU) || (op == MULHU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes.
// Multiply: {hi,lo} holds partial product / remaining multiplier bits (shift-add, right shift).
// Divide:   hi holds the partial remainder, lo the dividend bits shifting out / quotient bits in.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] shift_s;

    // Single shift-add or restoring shift-subtract step
    always_comb begin
        sum_s   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(XLEN+1){1'b0}});
        shift_s = {hi_i, lo_i[XLEN-1]};
        if (is_div_i) begin
            if (shift_s >= {1'b0, b_i}) begin
                // Remainder is always below the divisor, so the difference fits XLEN bits
                hi_o = shift_s[XLEN-1:0] - b_i;
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shift_s[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = sum_s[XLEN:1];
            lo_o = {sum_s[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: sign-magnitude conversion at accept,
// XLEN radix-2 steps, one sign fix-up cycle, then result hold until consumed.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_t           op_q, op_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic             neg_q, neg_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic              accept_s, a_neg_s, b_neg_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s, step_hi_s, step_lo_s, fix_res_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic              step_div_s;

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = valid_q;
    assign result_o   = result_q;
    assign step_div_s = is_div(op_q);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (step_div_s),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi_s),
        .lo_o     (step_lo_s)
    );

    // Operand conditioning: signs, magnitudes and 1-cycle special cases
    always_comb begin
        accept_s   = valid_i && (state_q == IDLE) && !flush_i;
        a_neg_s    = is_signed_rs1(op_i) && data1_i[XLEN-1];
        b_neg_s    = is_signed_rs2(op_i) && data2_i[XLEN-1];
        a_mag_s    = a_neg_s ? ({XLEN{1'b0}} - data1_i) : data1_i;
        b_mag_s    = b_neg_s ? ({XLEN{1'b0}} - data2_i) : data2_i;
        div_zero_s = is_div(op_i) && (data2_i == {XLEN{1'b0}});
        div_ovf_s  = is_div(op_i) && is_signed_rs1(op_i)
                     && (data1_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (data2_i == {XLEN{1'b1}});
    end

    // Sign fix-up of the finished magnitude result
    always_comb begin
        prod_s     = {hi_q, lo_q};
        prod_fix_s = neg_q ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        fix_res_s  = {XLEN{1'b0}};
        if (is_div(op_q)) begin
            if (is_rem(op_q)) begin
                fix_res_s = neg_q ? ({XLEN{1'b0}} - hi_q) : hi_q;
            end else begin
                fix_res_s = neg_q ? ({XLEN{1'b0}} - lo_q) : lo_q;
            end
        end else if (is_high(op_q)) begin
            fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
        end else begin
            fix_res_s = prod_fix_s[XLEN-1:0];
        end
    end

    // FSM next-state and datapath register updates; flush wins over everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        valid_d  = valid_q;
        result_d = result_q;
        if (flush_i) begin
            state_d  = IDLE;
            cnt_d    = {CNT_W{1'b0}};
            valid_d  = 1'b0;
            result_d = {XLEN{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        op_d = op_i;
                        if (div_zero_s) begin
                            state_d  = DONE;
                            valid_d  = 1'b1;
                            result_d = is_rem(op_i) ? data1_i : {XLEN{1'b1}};
                        end else if (div_ovf_s) begin
                            state_d  = DONE;
                            valid_d  = 1'b1;
                            result_d = is_rem(op_i) ? {XLEN{1'b0}} : data1_i;
                        end else begin
                            state_d = CALC;
                            cnt_d   = {CNT_W{1'b0}};
                            hi_d    = {XLEN{1'b0}};
                            lo_d    = a_mag_s;
                            b_d     = b_mag_s;
                            // Remainder follows rs1; quotient/product follow the sign product
                            neg_d   = is_rem(op_i) ? a_neg_s : (a_neg_s ^ b_neg_s);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    hi_d  = step_hi_s;
                    lo_d  = step_lo_s;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
                FIX: begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = fix_res_s;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d  = IDLE;
                        valid_d  = 1'b0;
                        result_d = {XLEN{1'b0}};
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    result_d = {XLEN{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= MUL;
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

endmodule
